if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch requester that drives the instruction memory read port (64-bit byte address in, 32-bit word out, combinational read) and delivers fetched instructions to decode.
- Holds the PC, advances it by 4 per fetched word, and buffers words in a 2-entry prefetch FIFO with a valid/ready handshake toward decode.
- Accepts branch/jump redirects that flush the buffer and restart fetch at a new PC.

Parameters:
- ADDR_W, 64, PC and memory address width.
- RESET_PC, 64'h0, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  1 = fetch allowed; 0 = hold PC, no push.
- imem_addr  output  ADDR_W  byte address to instruction memory; always equals current PC.
- imem_rdata  input  32  word returned combinationally for imem_addr.
- out_valid  output  1  head FIFO entry is presentable to decode.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  ADDR_W  PC of the instruction at FIFO head.
- redirect_valid  input  1  redirect request this cycle.
- redirect_pc  input  ADDR_W  target PC.
- misalign_err  output  1  sticky: a redirect target had bits [1:0] ≠ 0.
- fetch_count  output  32  number of words pushed since reset; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (rst=1 at edge): pc ← RESET_PC; FIFO emptied (count=0, rd/wr pointers 0); misalign_err ← 0; fetch_count ← 0. While rst=1, out_valid=0 and imem_addr=RESET_PC. rst dominates redirect and all handshakes, including mid-operation.
- imem_addr = pc, combinational from the PC register.
- pop = out_valid & out_ready.
- can_push = fetch_en & !redirect_valid & (count < DEPTH | pop). Full FIFO with a same-cycle pop may push.
- On push: FIFO entry ← {pc, imem_rdata}; pc ← pc + 4, wrapping modulo 2^ADDR_W (all-ones−3 → 0); fetch_count increments unless saturated.
- out_valid = (count ≠ 0) & !redirect_valid. Stale head is never presented in a redirect cycle.
- out_instr/out_pc come from the head entry, which is register-sourced. They are stable while out_valid=1 & out_ready=0.
- Redirect (redirect_valid=1, rst=0):
  - FIFO flushed (count ← 0); no pop and no push that cycle.
  - pc ← {redirect_pc[ADDR_W-1:2], 2'b00}.
  - If redirect_pc[1:0] ≠ 0, misalign_err ← 1 (sticky until reset).
  - The first word at the target is pushed the next cycle and presented with out_valid=1 one cycle after that.
- Latency:
  - Reset release to first out_valid is 1 cycle (push at cycle 0, visible at cycle 1).
  - Redirect to first valid target is 2 cycles.
- Empty FIFO: no bypass; a word pushed this cycle is visible next cycle.
- fetch_en=0: PC and pushes freeze; pops still drain the FIFO.
- count updates by push minus pop. A simultaneous push and pop leaves count unchanged and advances both pointers, which wrap at DEPTH.
- Throughput: 1 instruction/cycle sustained when out_ready=1.

Test Plan:
- Reset, RESET_PC=0, memory words 0x00E12423@0, 0x00812703@4, 0x00A98933@8; out_ready=1 → cycle 1: out_pc=0/out_instr=0x00E12423; cycle 2: 4/0x00812703; cycle 3: 8/0x00A98933; fetch_count=3 after cycle 2 edge.
- out_ready=0 after reset → FIFO fills in 2 cycles; imem_addr holds at 8; head stays pc 0; raise out_ready → pc 0, 4, 8 delivered in order with no gaps or duplicates.
- Redirect to 24 while FIFO holds pcs 4,8 → out_valid=0 that cycle; next cycle imem_addr=24; following cycle out_pc=24, out_instr=0x00A98763; pcs 4,8 never delivered.
- Redirect to 0x1E → pc=0x1C; misalign_err=1 and stays 1 across later redirects until rst.
- pc set near top via redirect to 64'hFFFF_FFFF_FFFF_FFFC → next pushed pc is 0 (wrap); rst asserted mid-stream with FIFO full → next cycle out_valid=0, imem_addr=RESET_PC, fetch_count=0.
- fetch_en=0 for 3 cycles with out_ready=1 → FIFO drains to empty, imem_addr constant; re-enable → fetch resumes at held PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the instruction memory and buffers
// fetched words in a small prefetch FIFO that decode drains via a valid/ready handshake.
module if_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_en,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]       i_imem_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_instr,
  output logic [ADDR_W-1:0] o_out_pc,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_misalign_err,
  output logic [31:0]       o_fetch_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_mem    [DEPTH];
  logic [31:0]       r_instr_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_misalign;
  logic [31:0]       r_fetch_count;

  logic              w_pop;
  logic              w_push;
  logic              w_has_room;
  logic [ADDR_W-1:0] w_target_pc;
  logic              w_target_misaligned;

  // A full FIFO may still accept a word in a cycle where decode takes the head.
  always_comb begin
    o_out_valid         = (r_count != '0) && !i_redirect_valid && !i_rst;
    w_pop               = o_out_valid && i_out_ready;
    w_has_room          = (r_count < FULL_CNT) || w_pop;
    w_push              = i_fetch_en && !i_redirect_valid && !i_rst && w_has_room;
    w_target_pc         = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    w_target_misaligned = (i_redirect_pc[1:0] != 2'b00);
  end

  always_comb begin
    o_imem_addr    = i_rst ? RESET_PC : r_pc;
    o_out_instr    = r_instr_mem[r_rd_ptr];
    o_out_pc       = r_pc_mem[r_rd_ptr];
    o_misalign_err = r_misalign;
    o_fetch_count  = r_fetch_count;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_pc <= w_target_pc;
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(4);
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_pc;
      r_instr_mem[r_wr_ptr] <= i_imem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misalign <= 1'b0;
    end else if (i_redirect_valid && w_target_misaligned) begin
      r_misalign <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_count <= '0;
    end else if (w_push && (r_fetch_count != 32'hFFFF_FFFF)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: expected deliveries are queued as stimulus is issued
// and a negedge monitor compares every accepted head entry against that queue.
module tb_if_fetch_unit;

  localparam int ADDR_W = 64;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchEn;
  logic [63:0] imemAddr;
  logic [31:0] imemRdata;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic [63:0] outPc;
  logic        redirectValid;
  logic [63:0] redirectPc;
  logic        misalignErr;
  logic [31:0] fetchCount;

  int passCount  = 0;
  int totalCount = 0;
  fetch_t expQ[$];

  always #5 clk = ~clk;

  if_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'h0), .DEPTH(2)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fetch_en       (fetchEn),
    .o_imem_addr      (imemAddr),
    .i_imem_rdata     (imemRdata),
    .o_out_valid      (outValid),
    .i_out_ready      (outReady),
    .o_out_instr      (outInstr),
    .o_out_pc         (outPc),
    .i_redirect_valid (redirectValid),
    .i_redirect_pc    (redirectPc),
    .o_misalign_err   (misalignErr),
    .o_fetch_count    (fetchCount)
  );

  // Instruction memory: a few hand-placed words, everything else a fixed address hash.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h00E12423;
      64'd4:   return 32'h00812703;
      64'd8:   return 32'h00A98933;
      64'd24:  return 32'h00A98763;
      default: return a[31:0] ^ 32'h13579BDF;
    endcase
  endfunction

  always_comb imemRdata = memWord(imemAddr);

  // Every accepted head entry must be the next one the scoreboard is waiting for.
  always @(negedge clk) begin : monitor
    fetch_t e;
    if (outValid && outReady) begin
      totalCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL delivery: got pc=%h instr=%h, required no delivery", outPc, outInstr);
      end else begin
        e = expQ.pop_front();
        if (outPc === e.pc && outInstr === e.instr) begin
          passCount++;
        end else begin
          $display("[TB] FAIL delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                   outPc, outInstr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic r, input logic fe, input logic ordy,
                               input logic rv, input logic [63:0] rpc);
    rst           = r;
    fetchEn       = fe;
    outReady      = ordy;
    redirectValid = rv;
    redirectPc    = rpc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    totalCount++;
    if (actual === required) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic expectFetch(input logic [63:0] pc, input logic [31:0] instr);
    fetch_t e;
    e.pc    = pc;
    e.instr = instr;
    expQ.push_back(e);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 64'h0);

    $display("[TB] streaming after reset");
    applyStimulus(1, 1, 1, 0, 64'h0);
    tick();
    expectFetch(64'd0, 32'h00E12423);
    expectFetch(64'd4, 32'h00812703);
    expectFetch(64'd8, 32'h00A98933);
    applyStimulus(0, 1, 1, 0, 64'h0);
    checkOutput("reset_out_valid", 64'(outValid), 64'd0);
    checkOutput("reset_imem_addr", imemAddr, 64'd0);
    checkOutput("reset_misalign", 64'(misalignErr), 64'd0);
    tick();
    tick();
    tick();
    checkOutput("stream_fetch_count", 64'(fetchCount), 64'd3);
    applyStimulus(0, 0, 1, 0, 64'h0);
    tick();
    checkOutput("stream_drained", 64'(outValid), 64'd0);
    checkOutput("stream_imem_addr", imemAddr, 64'd12);
    checkOutput("stream_sb_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] backpressure fill and release");
    applyStimulus(1, 1, 0, 0, 64'h0);
    tick();
    expectFetch(64'd0, 32'h00E12423);
    expectFetch(64'd4, 32'h00812703);
    expectFetch(64'd8, 32'h00A98933);
    applyStimulus(0, 1, 0, 0, 64'h0);
    tick();
    tick();
    checkOutput("bp_imem_addr_full", imemAddr, 64'd8);
    checkOutput("bp_valid_full", 64'(outValid), 64'd1);
    checkOutput("bp_head_pc", outPc, 64'd0);
    tick();
    checkOutput("bp_imem_addr_hold", imemAddr, 64'd8);
    checkOutput("bp_head_pc_stable", outPc, 64'd0);
    checkOutput("bp_head_instr_stable", 64'(outInstr), 64'h00E12423);
    checkOutput("bp_fetch_count", 64'(fetchCount), 64'd2);
    applyStimulus(0, 1, 1, 0, 64'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 64'h0);
    tick();
    tick();
    checkOutput("bp_drained", 64'(outValid), 64'd0);
    checkOutput("bp_sb_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] redirect flush");
    applyStimulus(1, 1, 1, 0, 64'h0);
    tick();
    expectFetch(64'd0, 32'h00E12423);
    expectFetch(64'd24, 32'h00A98763);
    applyStimulus(0, 1, 1, 0, 64'h0);
    tick();
    tick();
    applyStimulus(0, 1, 0, 0, 64'h0);
    tick();
    applyStimulus(0, 1, 1, 1, 64'd24);
    checkOutput("redir_valid_masked", 64'(outValid), 64'd0);
    tick();
    applyStimulus(0, 1, 1, 0, 64'h0);
    checkOutput("redir_imem_addr", imemAddr, 64'd24);
    checkOutput("redir_flushed", 64'(outValid), 64'd0);
    tick();
    checkOutput("redir_target_pc", outPc, 64'd24);
    checkOutput("redir_target_instr", 64'(outInstr), 64'h00A98763);
    applyStimulus(0, 0, 1, 0, 64'h0);
    tick();
    checkOutput("redir_drained", 64'(outValid), 64'd0);
    checkOutput("redir_sb_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] misaligned redirect");
    applyStimulus(1, 0, 0, 0, 64'h0);
    tick();
    applyStimulus(0, 0, 0, 1, 64'h1E);
    tick();
    applyStimulus(0, 0, 0, 0, 64'h0);
    checkOutput("mis_aligned_pc", imemAddr, 64'h1C);
    checkOutput("mis_flag_set", 64'(misalignErr), 64'd1);
    applyStimulus(0, 0, 0, 1, 64'h40);
    tick();
    applyStimulus(0, 0, 0, 0, 64'h0);
    checkOutput("mis_second_pc", imemAddr, 64'h40);
    checkOutput("mis_flag_sticky", 64'(misalignErr), 64'd1);
    applyStimulus(1, 0, 0, 0, 64'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 64'h0);
    checkOutput("mis_flag_cleared", 64'(misalignErr), 64'd0);

    $display("[TB] pc wrap and mid-stream reset");
    applyStimulus(1, 0, 0, 0, 64'h0);
    tick();
    expectFetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hECA86423);
    applyStimulus(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    applyStimulus(0, 1, 1, 0, 64'h0);
    checkOutput("wrap_top_pc", imemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    checkOutput("wrap_pc_zero", imemAddr, 64'd0);
    checkOutput("wrap_head_top", outPc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    applyStimulus(0, 1, 0, 0, 64'h0);
    checkOutput("wrap_next_pc", outPc, 64'd0);
    checkOutput("wrap_next_instr", 64'(outInstr), 64'h00E12423);
    tick();
    applyStimulus(1, 1, 1, 0, 64'h0);
    checkOutput("rst_valid_low", 64'(outValid), 64'd0);
    checkOutput("rst_imem_addr", imemAddr, 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 64'h0);
    checkOutput("rst_after_valid", 64'(outValid), 64'd0);
    checkOutput("rst_after_addr", imemAddr, 64'd0);
    checkOutput("rst_after_count", 64'(fetchCount), 64'd0);
    checkOutput("wrap_sb_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] fetch disable drain");
    applyStimulus(1, 1, 0, 0, 64'h0);
    tick();
    expectFetch(64'd0, 32'h00E12423);
    expectFetch(64'd4, 32'h00812703);
    expectFetch(64'd8, 32'h00A98933);
    applyStimulus(0, 1, 0, 0, 64'h0);
    tick();
    tick();
    applyStimulus(0, 0, 1, 0, 64'h0);
    checkOutput("hold_addr_c0", imemAddr, 64'd8);
    tick();
    checkOutput("hold_addr_c1", imemAddr, 64'd8);
    tick();
    checkOutput("hold_addr_c2", imemAddr, 64'd8);
    checkOutput("hold_empty", 64'(outValid), 64'd0);
    tick();
    checkOutput("hold_addr_c3", imemAddr, 64'd8);
    applyStimulus(0, 1, 1, 0, 64'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 64'h0);
    tick();
    checkOutput("resume_drained", 64'(outValid), 64'd0);
    checkOutput("resume_addr", imemAddr, 64'd12);
    checkOutput("resume_count", 64'(fetchCount), 64'd3);
    checkOutput("resume_sb_empty", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
